// File: rtl/hpc2_rnd_scheduler_pkg.sv
// Shared HPC2 definitions: the gadget randomness width function and the
// scheduler state encoding. Both the gadgets and the scheduler take RW from
// hpc2rnd() so the two widths always agree.
package hpc2_rnd_scheduler_pkg;

  // Fresh random bits consumed by one HPC2 AND invocation with d shares.
  function automatic int hpc2rnd(input int shares);
    return shares * (shares - 1) / 2;
  endfunction

  // INIT: filling the buffer, no grants. RUN: serving requesters.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/hpc2_rnd_scheduler_rnd_fifo2.sv
// Two-entry FIFO of random words. Entry 0 is always the head, so a pop is a
// shift and the head is available combinationally. Contents are zeroed on
// reset and on clear so that discarded randomness never lingers in flops.
module rnd_fifo2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   level
);

  logic [W-1:0] mem_reg [2];
  logic [1:0]   level_reg;
  logic         pop_ok;
  logic         push_ok;

  // A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
  // when the same cycle frees a slot.
  always_comb begin
    pop_ok  = pop && (level_reg != 2'd0);
    push_ok = push && ((level_reg != 2'd2) || pop_ok);
  end

  // Storage and occupancy update, head kept in entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      level_reg  <= 2'd0;
    end else if (clr) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      level_reg  <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (level_reg == 2'd0) mem_reg[0] <= din;
          else                   mem_reg[1] <= din;
          level_reg <= level_reg + 2'd1;
        end
        2'b01: begin
          mem_reg[0] <= mem_reg[1];
          mem_reg[1] <= '0;
          level_reg  <= level_reg - 2'd1;
        end
        2'b11: begin
          // Level unchanged; the pushed word lands behind whatever remains.
          if (level_reg == 2'd1) begin
            mem_reg[0] <= din;
          end else begin
            mem_reg[0] <= mem_reg[1];
            mem_reg[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = mem_reg[0];
  assign level = level_reg;

endmodule

// File: rtl/hpc2_rnd_scheduler.sv
// Fresh-randomness scheduler for HPC2 gadgets: buffers PRNG words in a
// 2-entry FIFO and hands each word to exactly one requester, chosen
// round-robin. Grants are combinational so the gadget consumes the word in
// the grant cycle; a word is popped on its grant and never reused.
(* fv_prop = "PINI", fv_strat = "flatten", fv_order = d *)
module hpc2_rnd_scheduler
  import hpc2_rnd_scheduler_pkg::*;
#(
  parameter int d    = 2,
  parameter int NREQ = 4,
  localparam int RW  = hpc2rnd(d)
) (
  input  logic            clk,
  input  logic            rst,
  (* fv_type = "random", fv_count = 1, fv_rnd_count_0 = RW *)
  input  logic [RW-1:0]   prng_rnd,
  input  logic            prng_valid,
  output logic            prng_ready,
  input  logic            flush,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  (* fv_type = "random", fv_count = 1, fv_rnd_count_0 = RW *)
  output logic [RW-1:0]   gnt_rnd,
  output logic [1:0]      level,
  output logic            running
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [PW-1:0] ONE_IDX  = PW'(1);

  sched_state_t  state_reg;
  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] grant_idx;
  logic          grant;
  logic          push;
  logic [RW-1:0] head;
  logic [1:0]    fifo_level;

  rnd_fifo2 #(
    .W(RW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (grant),
    .din   (prng_rnd),
    .head  (head),
    .level (fifo_level)
  );

  // Accept PRNG words while there is room, never during flush or reset.
  always_comb begin
    prng_ready = !rst && (fifo_level != 2'd2) && !flush;
    push       = prng_valid && prng_ready;
  end

  // Round-robin arbiter: first requester at or after ptr, only in RUN with data.
  always_comb begin
    logic [PW-1:0] idx;
    gnt       = '0;
    grant     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    if ((state_reg == ST_RUN) && (fifo_level != 2'd0) && !flush) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = PW'((int'(ptr_reg) + k) % NREQ);
        if (!grant && req[idx]) begin
          gnt[idx]  = 1'b1;
          grant     = 1'b1;
          grant_idx = idx;
        end
      end
    end
  end

  // Only the granted requester sees the head word; otherwise drive zeros.
  always_comb begin
    gnt_rnd = grant ? head : '0;
  end

  // State and pointer: flush dominates, INIT waits for a full buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_INIT;
      ptr_reg   <= '0;
    end else if (flush) begin
      state_reg <= ST_INIT;
    end else begin
      case (state_reg)
        ST_INIT: begin
          // Enter RUN in the same edge that makes the buffer full.
          if ((fifo_level == 2'd2) || ((fifo_level == 2'd1) && push))
            state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (grant)
            ptr_reg <= (grant_idx == LAST_IDX) ? '0 : grant_idx + ONE_IDX;
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  assign level   = fifo_level;
  assign running = (state_reg == ST_RUN);

endmodule

// File: tb/tb_hpc2_rnd_scheduler.sv
// Scoreboard bench for hpc2_rnd_scheduler: the stimulus process queues each
// expected grant; a negedge monitor pops and compares whenever gnt is nonzero.
module tb_hpc2_rnd_scheduler;

  localparam int D    = 2;
  localparam int NREQ = 4;
  localparam int RW   = 1;

  logic            clk;
  logic            rst;
  logic [RW-1:0]   prng_rnd;
  logic            prng_valid;
  logic            prng_ready;
  logic            flush;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [RW-1:0]   gnt_rnd;
  logic [1:0]      level;
  logic            running;

  typedef struct {
    logic [NREQ-1:0] g;
    logic [RW-1:0]   w;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  hpc2_rnd_scheduler #(
    .d(D),
    .NREQ(NREQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prng_rnd   (prng_rnd),
    .prng_valid (prng_valid),
    .prng_ready (prng_ready),
    .flush      (flush),
    .req        (req),
    .gnt        (gnt),
    .gnt_rnd    (gnt_rnd),
    .level      (level),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [NREQ-1:0] r, input logic pv, input logic [RW-1:0] w,
                       input logic fl);
    req        = r;
    prng_valid = pv;
    prng_rnd   = w;
    flush      = fl;
  endtask

  task automatic expect_gnt(input logic [NREQ-1:0] g, input logic [RW-1:0] w);
    exp_t e;
    e.g = g;
    e.w = w;
    exp_q.push_back(e);
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every nonzero grant must match the oldest expectation.
  always @(negedge clk) begin
    if (!done) begin
      if (gnt != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: gnt=%b rnd=%h, no grant expected at %0t", gnt, gnt_rnd, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("grant gnt=%b rnd=%h (expected gnt=%b rnd=%h)", gnt, gnt_rnd, e.g, e.w);
          chk("grant_gnt", 32'(gnt), 32'(e.g));
          chk("grant_rnd", 32'(gnt_rnd), 32'(e.w));
        end
      end else begin
        chk("idle_rnd_zero", 32'(gnt_rnd), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive('0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    neg();
    chk("rst_ready", 32'(prng_ready), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rnd", 32'(gnt_rnd), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_level", 32'(level), 0);
    pos();
    rst = 1'b0;

    // Initial fill: no grants until the buffer is full.
    drive(4'b1111, 1'b1, 1'b1, 1'b0); neg();
    chk("c1_ready", 32'(prng_ready), 1);
    chk("c1_running", 32'(running), 0);
    pos();
    drive(4'b1111, 1'b1, 1'b0, 1'b0); neg();
    chk("c2_level", 32'(level), 1);
    chk("c2_running", 32'(running), 0);
    pos();
    drive(4'b1111, 1'b0, 1'b0, 1'b0); expect_gnt(4'b0001, 1'b1); neg();
    chk("c3_running", 32'(running), 1);
    chk("c3_level", 32'(level), 2);
    chk("c3_ready_full", 32'(prng_ready), 0);
    pos();

    // Push and grant together at level 1.
    drive(4'b1111, 1'b1, 1'b1, 1'b0); expect_gnt(4'b0010, 1'b0); neg();
    chk("c4_level", 32'(level), 1);
    pos();
    drive(4'b0000, 1'b0, 1'b0, 1'b0); neg();
    chk("c5_level_same", 32'(level), 1);
    pos();
    drive(4'b1111, 1'b0, 1'b0, 1'b0); expect_gnt(4'b0100, 1'b1); pos();

    // Drain to empty stays in RUN; refill.
    drive(4'b0000, 1'b1, 1'b1, 1'b0); neg();
    chk("c7_level_empty", 32'(level), 0);
    chk("c7_running", 32'(running), 1);
    pos();
    drive(4'b0000, 1'b1, 1'b0, 1'b0); pos();

    // Two requesters, no PRNG supply.
    drive(4'b0011, 1'b0, 1'b0, 1'b0); expect_gnt(4'b0001, 1'b1); neg();
    chk("c9_level", 32'(level), 2);
    pos();
    drive(4'b0011, 1'b0, 1'b0, 1'b0); expect_gnt(4'b0010, 1'b0); pos();
    drive(4'b0011, 1'b0, 1'b0, 1'b0); neg();
    chk("c11_level", 32'(level), 0);
    chk("c11_running", 32'(running), 1);
    pos();

    // Refill, then full rotation with one PRNG word per cycle.
    drive(4'b0000, 1'b1, 1'b1, 1'b0); pos();
    drive(4'b0000, 1'b1, 1'b0, 1'b0); pos();
    drive(4'b1111, 1'b1, 1'b1, 1'b0); expect_gnt(4'b0100, 1'b1); neg();
    chk("c14_ready", 32'(prng_ready), 0);
    pos();
    drive(4'b1111, 1'b1, 1'b1, 1'b0); expect_gnt(4'b1000, 1'b0); neg();
    chk("c15_ready", 32'(prng_ready), 1);
    pos();
    drive(4'b1111, 1'b1, 1'b0, 1'b0); expect_gnt(4'b0001, 1'b1); pos();
    drive(4'b1111, 1'b1, 1'b1, 1'b0); expect_gnt(4'b0010, 1'b0); pos();
    drive(4'b1111, 1'b1, 1'b0, 1'b0); expect_gnt(4'b0100, 1'b1); pos();
    drive(4'b0000, 1'b1, 1'b1, 1'b0); neg();
    chk("c19_level", 32'(level), 1);
    pos();

    // Flush at level 2.
    drive(4'b1111, 1'b1, 1'b1, 1'b1); neg();
    chk("flush_level", 32'(level), 2);
    chk("flush_ready", 32'(prng_ready), 0);
    chk("flush_gnt", 32'(gnt), 0);
    chk("flush_rnd", 32'(gnt_rnd), 0);
    pos();
    drive(4'b1111, 1'b0, 1'b0, 1'b0); neg();
    chk("post_flush_level", 32'(level), 0);
    chk("post_flush_running", 32'(running), 0);
    pos();
    drive(4'b1111, 1'b1, 1'b1, 1'b0); pos();
    drive(4'b1111, 1'b1, 1'b0, 1'b0); neg();
    chk("refill_running", 32'(running), 0);
    pos();
    // Pointer held across flush: next in line is requester 3.
    drive(4'b1111, 1'b0, 1'b0, 1'b0); expect_gnt(4'b1000, 1'b1); neg();
    chk("refill_run", 32'(running), 1);
    pos();

    // Asynchronous reset mid-stream at level 1.
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    drive(4'b1111, 1'b1, 1'b1, 1'b0);
    #1;
    chk("arst_ready", 32'(prng_ready), 0);
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_rnd", 32'(gnt_rnd), 0);
    chk("arst_running", 32'(running), 0);
    chk("arst_level", 32'(level), 0);
    pos();
    rst = 1'b0;
    drive(4'b1111, 1'b1, 1'b1, 1'b0); neg();
    chk("rel_level", 32'(level), 0);
    chk("rel_running", 32'(running), 0);
    pos();
    drive(4'b1111, 1'b1, 1'b0, 1'b0); neg();
    chk("rel_running2", 32'(running), 0);
    pos();
    drive(4'b1111, 1'b0, 1'b0, 1'b0); expect_gnt(4'b0001, 1'b1); neg();
    chk("rel_level_full", 32'(level), 2);
    pos();
    drive(4'b0000, 1'b0, 1'b0, 1'b0); neg();
    chk("final_level", 32'(level), 1);
    pos();

    done = 1'b1;
    chk("all_grants_seen", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hpc2_rnd_scheduler.md
HPC2_RND_SCHEDULER -- requirements
Module: hpc2_rnd_scheduler

Interface
REQ-001 The block SHALL have parameter d, default 2, meaning the number of shares per masked value.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning the number of HPC2 gadget requesters (2..8).
REQ-003 The block SHALL have derived localparam RW = hpc2rnd = d*(d-1)/2, meaning the fresh-random bits consumed by one HPC2 AND invocation.
REQ-004 The block SHALL have one clock, clk, and asynchronous active-high reset rst: clk input 1 system clock; rst input 1 async active-high reset.
REQ-005 Port prng_rnd, input, RW bits: random word from the PRNG.
REQ-006 Port prng_valid, input, 1 bit: prng_rnd is valid.
REQ-007 Port prng_ready, output, 1 bit: the block accepts prng_rnd this cycle.
REQ-008 Port flush, input, 1 bit: discard all buffered randomness (reseed event).
REQ-009 Port req, input, NREQ bits: per-requester request for one fresh random word.
REQ-010 Port gnt, output, NREQ bits: one-hot or zero grant.
REQ-011 Port gnt_rnd, output, RW bits: random word for the granted requester, which drives it onto its gadget rnd input in the same cycle.
REQ-012 Port level, output, 2 bits: buffer occupancy (0..2).
REQ-013 Port running, output, 1 bit: high when in state RUN.

Function
REQ-014 The block SHALL contain a 2-entry FIFO of RW-bit words; push = prng_valid & prng_ready; prng_ready = (level != 2) & !flush.
REQ-015 The FSM SHALL have states INIT and RUN; INIT->RUN when level reaches 2; RUN->INIT on flush; no other transitions.
REQ-016 In INIT, gnt SHALL be 0 regardless of req.
REQ-017 In RUN, gnt SHALL be combinational: when level != 0 and req != 0 and !flush, exactly one bit is set, selected round-robin starting from pointer ptr; otherwise gnt = 0.
REQ-018 gnt_rnd SHALL equal the FIFO head word whenever gnt != 0; when gnt = 0, gnt_rnd SHALL be all-zero, so that no buffered randomness is exposed.
REQ-019 Each grant SHALL pop the head, so a word is delivered at most once; no word is ever duplicated to two requesters.
REQ-020 On a grant to index i, ptr SHALL become (i+1) mod NREQ at the next edge; without a grant, ptr SHALL hold.
REQ-021 A simultaneous push and pop SHALL leave level unchanged and preserve FIFO order.
REQ-022 A pop at level 1 with a push the same cycle SHALL present the pushed word as the head next cycle.
REQ-023 Flush SHALL have priority over push, pop and grant: at the next edge level = 0 and state = INIT; ptr holds.
REQ-024 Latency SHALL be 0 cycles from req to gnt; a PRNG word is grantable at the earliest 1 cycle after acceptance.
REQ-025 Starvation bound: a requester holding req high SHALL be granted within NREQ grants.

Reset
REQ-026 On rst, the block SHALL asynchronously set state = INIT, level = 0, ptr = 0, and FIFO contents to zero.
REQ-027 During reset, outputs SHALL be prng_ready = 0, gnt = 0, gnt_rnd = 0, running = 0, level = 0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; after release, the block SHALL refill from empty.

Structure
REQ-029 The hpc2rnd width function SHALL remain in the shared HPC2 header, which the block includes, so RW cannot diverge from the gadget's rnd width.
REQ-030 The FIFO SHALL be one sub-module, rnd_fifo2 (parameter W, 2 entries, async active-high rst); the arbiter and FSM SHALL reside in the top.
REQ-031 The block SHALL carry fullverif annotations: prng_rnd as random, gnt_rnd as random output, d as the order.

Verification
REQ-032 Scenario: reset, then prng_valid = 1 with words 0x1, 0x0, with req = 4'b1111 throughout -> gnt = 0 until running = 1 in the cycle after the 2nd accept; then gnt = 0001 with gnt_rnd = 0x1.
REQ-033 Scenario: RUN, level = 2, req = 4'b1111 held, PRNG supplying 1 word/cycle -> gnt sequence 0001, 0010, 0100, 1000, 0001; every gnt_rnd word appears exactly once.
REQ-034 Scenario: RUN, level = 1, push of 0x1 and grant in the same cycle -> level stays 1; the next grant returns 0x1.
REQ-035 Scenario: prng_valid = 0, req = 4'b0011, level = 2 -> two grants (0001, then 0010), then gnt = 0 with level = 0; state remains RUN.
REQ-036 Scenario: flush asserted with level = 2 and req = 4'b1111 -> gnt = 0 that cycle, prng_ready = 0; next cycle level = 0, running = 0.
REQ-037 Scenario: rst pulsed mid-stream at level = 1 -> all outputs zero immediately; the first grant after release occurs only after 2 fresh accepts.
